// File: rtl/mips_pkg.sv
// Shared widths and payload types for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned FETCH_QDEPTH = 2;
  localparam int unsigned FETCH_CNT_W  = $clog2(FETCH_QDEPTH + 1);

  // One fetched instruction as handed to decode: pc holds its word address + 1.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO with simultaneous push/pop and a one-cycle flush.
// The head slot is a register that directly drives the IF/ID outputs.
module fetch_queue
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic [FETCH_CNT_W-1:0] count
);

  fetch_entry_t tail;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count < FETCH_CNT_W'(FETCH_QDEPTH)) || pop_ok);

  // Shift-style storage: pops move the tail into the head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == '0) begin
            head <= push_data;
          end else begin
            tail <= push_data;
          end
          count <= count + FETCH_CNT_W'(1);
        end
        2'b01: begin
          head  <= tail;
          count <= count - FETCH_CNT_W'(1);
        end
        2'b11: begin
          if (count == FETCH_CNT_W'(1)) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, request issue, squash of stale responses and IF/ID queue.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump,
  input  logic [WORD_W-1:0] addr,
  input  logic              stall,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              valid_if_id,
  output logic [WORD_W-1:0] pc_if_id,
  output logic [WORD_W-1:0] ir_if_id,
  output logic [WORD_W-1:0] perf_fetch,
  output logic [WORD_W-1:0] perf_flush,
  output logic [WORD_W-1:0] perf_stall
);

  localparam int unsigned OCC_W = FETCH_CNT_W + 1;

  logic [WORD_W-1:0]      pc;
  logic [WORD_W-1:0]      req_pc;
  logic                   inflight;
  logic                   squash;
  logic [FETCH_CNT_W-1:0] count;
  logic [OCC_W-1:0]       occupancy;
  fetch_entry_t           head;
  fetch_entry_t           push_data;
  logic                   pop;
  logic                   push;
  logic                   accept;
  logic                   redirect;

  assign valid_if_id = (count != '0);
  assign pc_if_id    = head.pc;
  assign ir_if_id    = head.instr;

  assign pop      = valid_if_id && !stall;
  assign redirect = jump && valid_if_id && !stall;

  // Slots already claimed after this cycle's pop; an in-flight request owns one.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign imem_req  = !rst && (occupancy < OCC_W'(FETCH_QDEPTH));
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // Responses after reset or belonging to a pre-redirect request are dropped.
  assign push      = imem_rvalid && inflight && !squash && !redirect;
  assign push_data = '{pc: req_pc + WORD_W'(1), instr: imem_rdata};

  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  // PC and request tracking; the memory answers exactly one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      inflight <= accept;
      squash   <= accept && redirect;
      if (accept) begin
        req_pc <= pc;
      end
      if (redirect) begin
        pc <= addr;
      end else if (accept) begin
        pc <= pc + WORD_W'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [WORD_W-1:0] fetch_cnt;
  logic [WORD_W-1:0] flush_cnt;
  logic [WORD_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) begin
        fetch_cnt <= fetch_cnt + WORD_W'(1);
      end
      if (redirect) begin
        flush_cnt <= flush_cnt + WORD_W'(1);
      end
      if (stall && valid_if_id) begin
        stall_cnt <= stall_cnt + WORD_W'(1);
      end
    end
  end

  assign perf_fetch = fetch_cnt;
  assign perf_flush = flush_cnt;
  assign perf_stall = stall_cnt;
`else
  assign perf_fetch = '0;
  assign perf_flush = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: scenario tasks plus a queue-based reference model
// and a zero-wait instruction memory that returns address * 2.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        jump;
  logic [31:0] addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_if_id;
  logic [31:0] pc_if_id;
  logic [31:0] ir_if_id;
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
  logic [31:0] perf_stall;

  fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .jump        (jump),
    .addr        (addr),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .valid_if_id (valid_if_id),
    .pc_if_id    (pc_if_id),
    .ir_if_id    (ir_if_id),
    .perf_fetch  (perf_fetch),
    .perf_flush  (perf_flush),
    .perf_stall  (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Memory environment
  logic        resp_pending;
  logic [31:0] resp_data;
  logic        inject;

  // Reference model: expected IF/ID contents as a plain queue
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_inflight;
  bit          m_squash;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;
  logic [31:0] m_stall;

  // Observations from the most recent cycle
  logic        o_req;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [31:0] o_pc;
  logic [31:0] o_ir;
  logic [31:0] o_pf;
  logic [31:0] o_pfl;
  logic [31:0] o_ps;

  // One clock cycle: inputs are already set at the falling edge.
  task automatic step();
    int          occ;
    bit          mv;
    bit          mpop;
    bit          mreq;
    bit          macc;
    bit          mredir;
    bit          mpush;
    ent_t        e;
    logic [31:0] ef;
    logic [31:0] efl;
    logic [31:0] es;
    imem_rvalid = resp_pending || inject;
    imem_rdata  = inject ? 32'hDEAD_BEEF : (resp_pending ? resp_data : 32'h0);
    #1;
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_valid = valid_if_id;
    o_pc    = pc_if_id;
    o_ir    = ir_if_id;
    o_pf    = perf_fetch;
    o_pfl   = perf_flush;
    o_ps    = perf_stall;

    mv   = (mq.size() != 0);
    mpop = mv && !stall;
    occ  = mq.size() + int'(m_inflight) - int'(mpop);
    mreq = !rst && (occ < 2);

    n_checks++;
    if (o_req !== mreq) begin
      n_fail++;
      $display("FAIL imem_req t=%0t: got %0b expected %0b", $time, o_req, mreq);
    end
    if (!rst) begin
      if (mreq) begin
        n_checks++;
        if (o_addr !== m_pc) begin
          n_fail++;
          $display("FAIL imem_addr t=%0t: got %h expected %h", $time, o_addr, m_pc);
        end
      end
      n_checks++;
      if (o_valid !== mv) begin
        n_fail++;
        $display("FAIL valid_if_id t=%0t: got %0b expected %0b", $time, o_valid, mv);
      end
      if (mv) begin
        n_checks++;
        if (o_pc !== mq[0].pc || o_ir !== mq[0].ir) begin
          n_fail++;
          $display("FAIL if_id_head t=%0t: got pc=%h ir=%h expected pc=%h ir=%h",
                   $time, o_pc, o_ir, mq[0].pc, mq[0].ir);
        end
      end
      ef  = PERF ? m_fetch : 32'h0;
      efl = PERF ? m_flush : 32'h0;
      es  = PERF ? m_stall : 32'h0;
      n_checks++;
      if (o_pf !== ef || o_pfl !== efl || o_ps !== es) begin
        n_fail++;
        $display("FAIL perf t=%0t: got fetch=%0d flush=%0d stall=%0d expected %0d %0d %0d",
                 $time, o_pf, o_pfl, o_ps, ef, efl, es);
      end
    end

    if (rst) begin
      mq.delete();
      m_pc       = RST_PC;
      m_req_pc   = 32'h0;
      m_inflight = 1'b0;
      m_squash   = 1'b0;
      m_fetch    = 32'h0;
      m_flush    = 32'h0;
      m_stall    = 32'h0;
    end else begin
      macc   = mreq && imem_ready;
      mredir = jump && mv && !stall;
      mpush  = imem_rvalid && m_inflight && !m_squash && !mredir;
      if (mpop) void'(mq.pop_front());
      if (mpush) begin
        e.pc = m_req_pc + 32'd1;
        e.ir = m_req_pc << 1;
        mq.push_back(e);
      end
      if (mredir) mq.delete();
      if (mpush) m_fetch = m_fetch + 32'd1;
      if (mredir) m_flush = m_flush + 32'd1;
      if (stall && mv) m_stall = m_stall + 32'd1;
      m_squash = macc && mredir;
      if (macc) m_req_pc = m_pc;
      if (mredir) m_pc = addr;
      else if (macc) m_pc = m_pc + 32'd1;
      m_inflight = macc;
    end

    resp_pending = o_req && imem_ready;
    resp_data    = o_addr << 1;
    inject       = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; jump = 1'b0; stall = 1'b0; addr = 32'h0; imem_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_ir !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ifid: got valid=%0b pc=%h ir=%h expected 0 0 0", o_valid, o_pc, o_ir);
    end
    n_checks++;
    if (o_pf !== 32'h0 || o_pfl !== 32'h0 || o_ps !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d %0d %0d expected 0 0 0", o_pf, o_pfl, o_ps);
    end
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req: got req=%0b addr=%h expected 1 %h", o_req, o_addr, RST_PC);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (k == 1) begin
        if (o_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_latency: got valid=%0b expected 0", o_valid);
        end
      end else if (o_valid !== 1'b1 || o_pc !== 32'(RST_PC + 32'(k) - 32'd1) ||
                   o_ir !== 32'((RST_PC + 32'(k) - 32'd2) << 1)) begin
        n_fail++;
        $display("FAIL stream_%0d: got valid=%0b pc=%h ir=%h expected 1 %h %h", k, o_valid, o_pc,
                 o_ir, 32'(RST_PC + 32'(k) - 32'd1), 32'((RST_PC + 32'(k) - 32'd2) << 1));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    logic [31:0] p0;
    stall = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    step();
    step();
    held  = mq[0].pc;
    stall = 1'b1;
    step();
    step();
    p0 = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) p0 = o_ps;
      n_checks++;
      if (o_req !== 1'b0 || o_valid !== 1'b1 || o_pc !== held) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got req=%0b valid=%0b pc=%h expected 0 1 %h", i, o_req,
                 o_valid, o_pc, held);
      end
    end
    stall = 1'b0;
    step();
    n_checks++;
    if (o_ps - p0 !== (PERF ? 32'd5 : 32'd0) || o_pc !== held) begin
      n_fail++;
      $display("FAIL stall_release: got stall_delta=%0d pc=%h expected %0d %h", o_ps - p0, o_pc,
               PERF ? 5 : 0, held);
    end
    step();
    n_checks++;
    if (o_pc !== held + 32'd1) begin
      n_fail++;
      $display("FAIL stall_next: got pc=%h expected %h", o_pc, held + 32'd1);
    end
  endtask

  task automatic test_jump();
    logic [31:0] p0;
    bit          seen_req;
    bit          found;
    stall = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    step();
    step();
    jump = 1'b1; addr = 32'h40;
    step();
    p0   = o_pfl;
    jump = 1'b0; addr = 32'h0;
    seen_req = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step();
      if (!seen_req && o_req) begin
        seen_req = 1'b1;
        n_checks++;
        if (o_addr !== 32'h40) begin
          n_fail++;
          $display("FAIL jump_target_req: got %h expected 00000040", o_addr);
        end
      end
      if (o_valid) begin
        found = 1'b1;
        n_checks++;
        if (o_pc !== 32'h41 || o_ir !== 32'h80 || o_pfl - p0 !== (PERF ? 32'd1 : 32'd0)) begin
          n_fail++;
          $display("FAIL jump_first_valid: got pc=%h ir=%h flush_delta=%0d expected 41 80 %0d",
                   o_pc, o_ir, o_pfl - p0, PERF ? 1 : 0);
        end
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL jump_timeout: got no valid instruction expected one within 8 cycles");
    end
  endtask

  task automatic test_jump_stall();
    logic [31:0] held;
    logic [31:0] p0;
    stall = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    step();
    step();
    held  = mq[0].pc;
    stall = 1'b1; jump = 1'b1; addr = 32'h77;
    step();
    p0 = o_pfl;
    step();
    step();
    stall = 1'b0; jump = 1'b0; addr = 32'h0;
    step();
    n_checks++;
    if (o_pc !== held || o_pfl !== p0) begin
      n_fail++;
      $display("FAIL jump_stall_ignored: got pc=%h flush=%0d expected %h %0d", o_pc, o_pfl, held, p0);
    end
    step();
    n_checks++;
    if (o_pc !== held + 32'd1) begin
      n_fail++;
      $display("FAIL jump_stall_seq: got pc=%h expected %h", o_pc, held + 32'd1);
    end
  endtask

  task automatic test_ready_low();
    logic [31:0] a0;
    bit          found;
    stall = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    step();
    step();
    step();
    a0 = m_pc;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (o_req !== 1'b1 || o_addr !== a0) begin
        n_fail++;
        $display("FAIL ready_hold_%0d: got req=%0b addr=%h expected 1 %h", i, o_req, o_addr, a0);
      end
    end
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_drain: got valid=%0b expected 0", o_valid);
    end
    imem_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      step();
      if (o_valid) begin
        found = 1'b1;
        n_checks++;
        if (o_pc !== a0 + 32'd1) begin
          n_fail++;
          $display("FAIL ready_recover: got pc=%h expected %h", o_pc, a0 + 32'd1);
        end
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got no valid instruction expected one within 6 cycles");
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    stall = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    inject = 1'b1;
    step();
    n_checks++;
    if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%0b req=%0b addr=%h expected 0 1 %h", o_valid, o_req,
               o_addr, RST_PC);
    end
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      step();
      if (o_valid) begin
        found = 1'b1;
        n_checks++;
        if (o_pc !== RST_PC + 32'd1 || o_ir !== RST_PC << 1) begin
          n_fail++;
          $display("FAIL reset_mid_restart: got pc=%h ir=%h expected %h %h", o_pc, o_ir,
                   RST_PC + 32'd1, RST_PC << 1);
        end
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL reset_mid_timeout: got no valid instruction expected one within 6 cycles");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 149) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      jump       = ($urandom_range(0, 7) == 0);
      addr       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      step();
    end
    rst = 1'b0; stall = 1'b0; jump = 1'b0; imem_ready = 1'b1; addr = 32'h0;
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; stall = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (o_valid !== 1'b1 || o_pc !== RST_PC + 32'd1 + 32'(k)) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got valid=%0b pc=%h expected 1 %h", k, o_valid, o_pc,
                 RST_PC + 32'd1 + 32'(k));
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    resp_pending = 1'b0;
    resp_data    = 32'h0;
    inject       = 1'b0;
    rst          = 1'b1;
    jump         = 1'b0;
    stall        = 1'b0;
    addr         = 32'h0;
    imem_ready   = 1'b1;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    m_pc         = RST_PC;
    m_req_pc     = 32'h0;
    m_inflight   = 1'b0;
    m_squash     = 1'b0;
    m_fetch      = 32'h0;
    m_flush      = 32'h0;
    m_stall      = 32'h0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_jump();
    test_jump_stall();
    test_ready_low();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
